// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic cells: FSM state encoding
// and the counter-width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold 0..width, so it needs clog2(width+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = ai - bi - bin, bout set on underflow.
module full_subtractor (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = ai ^ bi ^ bin;
    assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock LSB first,
// start/done handshake with the result held until the next operation.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] dsh;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;
    logic             last;
    logic             load;

    full_subtractor u_fs (
        .ai  (a_sh[0]),
        .bi  (b_sh[0]),
        .bin (borrow),
        .d   (d),
        .bout(bout)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    // A start is taken whenever no shift is in flight, including the DONE cycle.
    assign load = start && (state != SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last)  state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            dsh        <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (load) begin
            a_sh   <= a;
            b_sh   <= b;
            dsh    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            dsh    <= {d, dsh[WIDTH-1:1]};
            borrow <= bout;
            cnt    <= cnt + 1'b1;
            // Publish on the DONE-entry edge, folding in the final bit directly.
            if (last) begin
                diff       <= {d, dsh[WIDTH-1:1]};
                borrow_out <= bout;
            end
        end
    end

endmodule
